// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, fixed-latency memory between the fetch
// stage (read-only) and the data stage (load/store). Issues a one-cycle command,
// counts LATENCY cycles, then returns a one-cycle rdy pulse to the winner.
// Optional macro MEM_ARB_FAIRNESS_EN: after two consecutive data grants that
// were made while fetch was also waiting, the next contended grant goes to fetch.
module mem_arbiter #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_rdy,
   output logic [DW-1:0] if_data,
   input  logic          d_req,
   input  logic          d_wr,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_rdy,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {StIdle, StCmd, StWait, StDone} state_t;

   localparam logic [3:0] LatM1 = 4'(LATENCY - 1);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          gnt_q, gnt_d;      // 1 = data stage owns the transaction
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          pick_data;

`ifdef MEM_ARB_FAIRNESS_EN
   logic [1:0]    fair_q, fair_d;

   // Data wins unless fetch has already lost twice in a row while waiting.
   always_comb begin
      pick_data = d_req && !(if_req && (fair_q == 2'd2));
   end
`else
   // Fixed data priority.
   always_comb begin
      pick_data = d_req;
   end
`endif

   // Next-state logic: arbitration in idle, latency countdown, release after done.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef MEM_ARB_FAIRNESS_EN
      fair_d  = fair_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (d_req || if_req) begin
               state_d = StCmd;
               cnt_d   = LatM1;
               gnt_d   = pick_data;
               addr_d  = pick_data ? d_addr : if_addr;
               wr_d    = pick_data & d_wr;
               wdata_d = pick_data ? d_wdata : '0;
`ifdef MEM_ARB_FAIRNESS_EN
               fair_d  = (pick_data && if_req) ? fair_q + 2'd1 : 2'd0;
`endif
            end
         end
         StCmd, StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StDone;
            end else begin
               state_d = StWait;
               cnt_d   = cnt_q - 4'd1;
            end
         end
         StDone: begin
            // Clearing the command registers here keeps mem_* at zero in idle.
            state_d = StIdle;
            cnt_d   = 4'd0;
            gnt_d   = 1'b0;
            wr_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and command registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         gnt_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef MEM_ARB_FAIRNESS_EN
         fair_q  <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef MEM_ARB_FAIRNESS_EN
         fair_q  <= fair_d;
`endif
      end
   end

   // Outputs decoded from state; read data passes through only during the rdy pulse.
   always_comb begin
      mem_en    = (state_q == StCmd);
      mem_wr    = wr_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      busy      = (state_q != StIdle);
      if_rdy    = (state_q == StDone) && !gnt_q;
      d_rdy     = (state_q == StDone) && gnt_q;
      if_data   = if_rdy ? mem_rdata : '0;
      d_rdata   = (d_rdy && !wr_q) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LATENCY=4 instance plus a LATENCY=1 instance.
// Stimulus pushes expected memory commands and rdy pulses; negedge monitors pop
// and compare them, together with idle/zero-data invariants.
module tb_mem_arbiter;

   typedef struct {
      int          cyc;
      int          kind;   // 0 = mem command, 1 = if_rdy, 2 = d_rdy
      logic [15:0] a;
      logic        wr;
      logic [15:0] d;
   } ev_t;

   ev_t q4[$];
   ev_t q1[$];
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // LATENCY=4 instance signals
   logic        if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
   logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic        if_rdy, d_rdy, mem_en, mem_wr, busy;
   logic [15:0] if_data, d_rdata, mem_addr, mem_wdata, mem_rdata;

   // LATENCY=1 instance signals
   logic        f_req = 1'b0, z_req = 1'b0, z_wr = 1'b0;
   logic [15:0] f_addr = '0, z_addr = '0, z_wdata = '0;
   logic        f_rdy, z_rdy, m1_en, m1_wr, busy1;
   logic [15:0] f_data, z_rdata, m1_addr, m1_wdata, m1_rdata;

   logic [15:0] mem [0:65535];
   logic [15:0] ra4, ra1;

   mem_arbiter #(.LATENCY(4), .AW(16), .DW(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdy(d_rdy), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.LATENCY(1), .AW(16), .DW(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .if_req(f_req), .if_addr(f_addr), .if_rdy(f_rdy), .if_data(f_data),
      .d_req(z_req), .d_wr(z_wr), .d_addr(z_addr), .d_wdata(z_wdata),
      .d_rdy(z_rdy), .d_rdata(z_rdata),
      .mem_en(m1_en), .mem_wr(m1_wr), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
      .mem_rdata(m1_rdata), .busy(busy1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: write on command, read address latched on command.
   always @(posedge clk) begin
      if (mem_en === 1'b1) begin
         if (mem_wr) mem[mem_addr] <= mem_wdata;
         ra4 <= mem_addr;
      end
      if (m1_en === 1'b1) ra1 <= m1_addr;
   end
   assign mem_rdata = mem[ra4];
   assign m1_rdata  = mem[ra1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic push(input int dut, input int c, input int k, input logic [15:0] a,
                       input logic wr, input logic [15:0] d);
      ev_t e;
      e.cyc = c; e.kind = k; e.a = a; e.wr = wr; e.d = d;
      if (dut == 4) q4.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic obs(input int dut, input int k, input logic [15:0] a, input logic wr,
                      input logic [15:0] d);
      ev_t e;
      if ((dut == 4 && q4.size() == 0) || (dut == 1 && q1.size() == 0)) begin
         total++;
         bad++;
         $display("FAIL unexpected dut%0d kind=%0d at cycle %0d: a=%0h d=%0h want none",
                  dut, k, cyc, a, d);
      end else begin
         e = (dut == 4) ? q4.pop_front() : q1.pop_front();
         chk($sformatf("dut%0d_ev_cycle", dut), 64'(cyc), 64'(e.cyc));
         chk($sformatf("dut%0d_ev_fields", dut), {29'd0, k[1:0], a, wr, d},
             {29'd0, e.kind[1:0], e.a, e.wr, e.d});
      end
   endtask

   // Monitors: pop on every DUT output event and check output invariants.
   always @(negedge clk) begin
      if (mem_en === 1'b1) obs(4, 0, mem_addr, mem_wr, mem_wdata);
      if (if_rdy === 1'b1) obs(4, 1, 16'h0, 1'b0, if_data);
      if (d_rdy === 1'b1)  obs(4, 2, 16'h0, 1'b0, d_rdata);
      if (if_rdy === 1'b1 || d_rdy === 1'b1) chk("rdy_overlap", 64'(if_rdy & d_rdy), 64'd0);
      if (busy === 1'b0) chk("idle_mem_zero", {31'd0, mem_wr, mem_addr, mem_wdata}, 64'd0);
      if (if_rdy === 1'b0) chk("if_data_zero", 64'(if_data), 64'd0);
      if (d_rdy === 1'b0)  chk("d_rdata_zero", 64'(d_rdata), 64'd0);
      if (m1_en === 1'b1) obs(1, 0, m1_addr, m1_wr, m1_wdata);
      if (f_rdy === 1'b1) obs(1, 1, 16'h0, 1'b0, f_data);
      if (z_rdy === 1'b1) obs(1, 2, 16'h0, 1'b0, z_rdata);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input bit data_side, input string nm);
      int n = 0;
      while (1) begin
         @(negedge clk);
         if (data_side ? (d_rdy === 1'b1) : (if_rdy === 1'b1)) break;
         n++;
         if (n > 40) begin
            chk({nm, "_timeout"}, 64'd1, 64'd0);
            break;
         end
      end
      tick(1);
   endtask

   task automatic fetch4(input logic [15:0] a, input logic [15:0] exp);
      int t = cyc;
      if_req = 1'b1; if_addr = a;
      push(4, t + 1, 0, a, 1'b0, 16'h0);
      push(4, t + 5, 1, 16'h0, 1'b0, exp);
      wait_rdy(1'b0, "fetch");
      if_req = 1'b0;
      chk("fetch_busy_after", 64'(busy), 64'd0);
   endtask

   task automatic dacc4(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp);
      int t = cyc;
      d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = wd;
      push(4, t + 1, 0, a, wr, wr ? wd : 16'h0);
      push(4, t + 5, 2, 16'h0, 1'b0, exp);
      wait_rdy(1'b1, "data");
      d_req = 1'b0;
      chk("data_busy_after", 64'(busy), 64'd0);
   endtask

   initial begin
      int t;
      mem[16'h0010] = 16'hA5A5;
      mem[16'h0020] = 16'h5A5A;
      mem[16'h0040] = 16'h0F0F;

      // Reset state.
      tick(3);
      chk("reset_outputs", {mem_en, mem_wr, if_rdy, d_rdy, busy, mem_addr, mem_wdata}, 64'd0);
      chk("reset_outputs_lat1", {m1_en, f_rdy, busy1, m1_addr}, 64'd0);
      rst_n = 1'b1;
      tick(2);

      // Single fetch.
      fetch4(16'h0010, 16'hA5A5);
      tick(2);

      // Store then load at the same address.
      dacc4(1'b1, 16'h0100, 16'h1234, 16'h0000);
      tick(1);
      dacc4(1'b0, 16'h0100, 16'h0000, 16'h1234);
      tick(1);

      // Simultaneous requests: data first, fetch granted in the following idle.
      t = cyc;
      if_req = 1'b1; if_addr = 16'h0020;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
      push(4, t + 1, 0, 16'h0100, 1'b0, 16'h0);
      push(4, t + 5, 2, 16'h0, 1'b0, 16'h1234);
      push(4, t + 7, 0, 16'h0020, 1'b0, 16'h0);
      push(4, t + 11, 1, 16'h0, 1'b0, 16'h5A5A);
      wait_rdy(1'b1, "both_d");
      d_req = 1'b0;
      wait_rdy(1'b0, "both_if");
      if_req = 1'b0;
      chk("both_busy_after", 64'(busy), 64'd0);
      tick(2);

      // Reset mid-transaction: command issued, no rdy ever.
      t = cyc;
      if_req = 1'b1; if_addr = 16'h0030;
      push(4, t + 1, 0, 16'h0030, 1'b0, 16'h0);
      tick(3);
      rst_n = 1'b0; if_req = 1'b0;
      tick(1);
      chk("midreset_outputs",
          {mem_en, mem_wr, if_rdy, d_rdy, busy, mem_addr, mem_wdata, if_data}, 64'd0);
      rst_n = 1'b1;
      tick(10);
      fetch4(16'h0010, 16'hA5A5);
      tick(1);

      // LATENCY=1: back-to-back fetches every 3 cycles.
      t = cyc;
      f_req = 1'b1; f_addr = 16'h0040;
      for (int k = 0; k < 3; k++) begin
         push(1, t + 3 * k + 1, 0, 16'h0040, 1'b0, 16'h0);
         push(1, t + 3 * k + 2, 1, 16'h0, 1'b0, 16'h0F0F);
      end
      tick(7);
      f_req = 1'b0;
      tick(4);
      chk("lat1_busy_after", 64'(busy1), 64'd0);

      // Both requests held: grant pattern with or without fairness.
      t = cyc;
      if_req = 1'b1; if_addr = 16'h0010;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
      for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_FAIRNESS_EN
         if (k % 3 == 2) begin
`else
         if (k < 0) begin
`endif
            push(4, t + 6 * k + 1, 0, 16'h0010, 1'b0, 16'h0);
            push(4, t + 6 * k + 5, 1, 16'h0, 1'b0, 16'hA5A5);
         end else begin
            push(4, t + 6 * k + 1, 0, 16'h0100, 1'b0, 16'h0);
            push(4, t + 6 * k + 5, 2, 16'h0, 1'b0, 16'h1234);
         end
      end
      tick(33);
      if_req = 1'b0; d_req = 1'b0;
      tick(8);
      chk("arb_busy_after", 64'(busy), 64'd0);

      chk("q4_drained", 64'(q4.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule
